// File: rtl/sha2_compress_core_pkg.sv
// Shared types, constants and round helpers for the SHA-2 compression engine.
package sha2_compress_core_pkg;

   typedef enum logic [1:0] {
      RESET  = 2'd0,
      IDLE   = 2'd1,
      UPDATE = 2'd2,
      DONE   = 2'd3
   } ShaState;

   // Eight 32-bit words; element 0 (a / H0) sits in the most significant bits.
   typedef logic [0:7][31:0] HashState;

   // Sixteen 32-bit message words; element 0 (W0) sits in bits [511:480].
   typedef logic [0:15][31:0] Chunk;

   localparam HashState H0_256 = {
      32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
      32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
   };

   localparam HashState H0_224 = {
      32'hc1059ed8, 32'h367cd507, 32'h3070dd17, 32'hf70e5939,
      32'hffc00b31, 32'h68581511, 32'h64f98fa7, 32'hbefa4fa4
   };

   localparam logic [0:63][31:0] K_TABLE = {
      32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
      32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
      32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
      32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
      32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
      32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
      32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
      32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
      32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
      32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
      32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
      32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
      32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
      32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
      32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
      32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
   };

   function automatic logic [31:0] rightRotate32(input logic [31:0] x, input int unsigned n);
      return (x >> n) | (x << (32 - n));
   endfunction

   function automatic logic [31:0] sigma0(input logic [31:0] x);
      return rightRotate32(x, 7) ^ rightRotate32(x, 18) ^ (x >> 3);
   endfunction

   function automatic logic [31:0] sigma1(input logic [31:0] x);
      return rightRotate32(x, 17) ^ rightRotate32(x, 19) ^ (x >> 10);
   endfunction

   function automatic logic [31:0] Sigma0(input logic [31:0] x);
      return rightRotate32(x, 2) ^ rightRotate32(x, 13) ^ rightRotate32(x, 22);
   endfunction

   function automatic logic [31:0] Sigma1(input logic [31:0] x);
      return rightRotate32(x, 6) ^ rightRotate32(x, 11) ^ rightRotate32(x, 25);
   endfunction

   function automatic logic [31:0] Ch(input logic [31:0] e, input logic [31:0] f,
                                      input logic [31:0] g);
      return (e & f) ^ (~e & g);
   endfunction

   function automatic logic [31:0] Maj(input logic [31:0] a, input logic [31:0] b,
                                       input logic [31:0] c);
      return (a & b) ^ (a & c) ^ (b & c);
   endfunction

   // One compression round: consumes K[t] and W[t], returns the shifted working vars.
   function automatic HashState sha_round(input HashState v, input logic [31:0] k,
                                          input logic [31:0] w);
      logic [31:0] t1;
      logic [31:0] t2;
      HashState    r;
      t1 = v[7] + Sigma1(v[4]) + Ch(v[4], v[5], v[6]) + k + w;
      t2 = Sigma0(v[0]) + Maj(v[0], v[1], v[2]);
      r[0] = t1 + t2;
      r[1] = v[0];
      r[2] = v[1];
      r[3] = v[2];
      r[4] = v[3] + t1;
      r[5] = v[4];
      r[6] = v[5];
      r[7] = v[6];
      return r;
   endfunction

endpackage

// File: rtl/sha2_compress_core_msg_schedule.sv
// Message schedule: 16-word sliding window that presents W[t..t+R-1] and
// generates R fresh words every time the core advances by R rounds.
module sha2_msg_schedule
   import sha2_compress_core_pkg::*;
#(
   parameter int ROUNDS_PER_CYCLE = 1
) (
   input  logic                               clk,
   input  logic                               rst_n,
   input  logic                               load,
   input  logic                               advance,
   input  Chunk                               chunk_in,
   output logic [0:ROUNDS_PER_CYCLE-1][31:0]  w_now
);

   localparam int R = ROUNDS_PER_CYCLE;

   Chunk        win_q;
   Chunk        win_d;
   logic [31:0] ext [16+R];

   // Extend the window by R words; later new words may depend on earlier new ones.
   always_comb begin
      for (int i = 0; i < 16; i++) begin
         ext[i] = win_q[i];
      end
      for (int j = 0; j < R; j++) begin
         ext[16+j] = sigma1(ext[14+j]) + ext[9+j] + sigma0(ext[1+j]) + ext[j];
      end
   end

   // Next window: fresh chunk on load, slide by R words on advance, else hold.
   always_comb begin
      win_d = win_q;
      if (load) begin
         win_d = chunk_in;
      end else if (advance) begin
         for (int i = 0; i < 16; i++) begin
            win_d[i] = ext[i+R];
         end
      end
   end

   // The oldest R words of the window are the ones consumed this cycle.
   always_comb begin
      for (int j = 0; j < R; j++) begin
         w_now[j] = win_q[j];
      end
   end

   // Window register with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         win_q <= '0;
      end else begin
         win_q <= win_d;
      end
   end

endmodule

// File: rtl/sha2_compress_core.sv
// SHA-256 / SHA-224 compression engine: accepts pre-padded 512-bit chunks,
// chains hash state across chunks of a message and holds the digest until taken.
module sha2_compress_core
   import sha2_compress_core_pkg::*;
#(
   parameter int ROUNDS_PER_CYCLE = 1,
   parameter bit OUT_REG          = 1'b1
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         mode_224,
   input  logic         chunk_valid,
   output logic         chunk_ready,
   input  logic [511:0] chunk_data,
   input  logic         chunk_last,
   output logic         digest_valid,
   input  logic         digest_ready,
   output logic [255:0] digest,
   output logic         busy
);

   localparam int R = ROUNDS_PER_CYCLE;

   if (R != 1 && R != 2 && R != 4 && R != 8) begin : g_bad_rounds
      $error("sha2_compress_core: ROUNDS_PER_CYCLE must be 1, 2, 4 or 8");
   end

   ShaState              state_q, state_d;
   logic [6:0]           cnt_q, cnt_d;
   HashState             work_q, work_d;
   HashState             h_q, h_d;
   logic                 first_q, first_d;
   logic                 last_q, last_d;
   logic                 mode_q, mode_d;
   logic                 oval_q, oval_d;
   logic [255:0]         dout_q, dout_d;

   HashState             round_v;
   logic [0:R-1][31:0]   w_now;
   logic                 sched_load;
   logic                 sched_adv;
   logic                 accept;
   logic                 take;
   logic [255:0]         h_flat;
   logic [255:0]         masked;

   sha2_msg_schedule #(
      .ROUNDS_PER_CYCLE (R)
   ) u_sched (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (sched_load),
      .advance  (sched_adv),
      .chunk_in (chunk_data),
      .w_now    (w_now)
   );

   assign chunk_ready  = (state_q == IDLE);
   assign busy         = (state_q == UPDATE) || (state_q == DONE);
   assign accept       = chunk_valid && chunk_ready;
   assign digest_valid = OUT_REG ? oval_q : (state_q == DONE);
   assign take         = digest_valid && digest_ready;
   assign h_flat       = h_q;
   assign masked       = mode_q ? {h_flat[255:32], 32'h0} : h_flat;
   assign digest       = OUT_REG ? dout_q : masked;

   // Chain R rounds back to back starting from the current round counter.
   always_comb begin
      round_v = work_q;
      for (int j = 0; j < R; j++) begin
         round_v = sha_round(round_v, K_TABLE[cnt_q[5:0] + 6'(j)], w_now[j]);
      end
   end

   // Next-state and datapath control; cnt_q reaching 64 marks the H update cycle.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      work_d     = work_q;
      h_d        = h_q;
      first_d    = first_q;
      last_d     = last_q;
      mode_d     = mode_q;
      sched_load = 1'b0;
      sched_adv  = 1'b0;
      case (state_q)
         RESET: begin
            state_d = IDLE;
            first_d = 1'b1;
         end
         IDLE: begin
            if (accept) begin
               sched_load = 1'b1;
               last_d     = chunk_last;
               cnt_d      = '0;
               first_d    = 1'b0;
               state_d    = UPDATE;
               if (first_q) begin
                  work_d = mode_224 ? H0_224 : H0_256;
                  h_d    = mode_224 ? H0_224 : H0_256;
                  mode_d = mode_224;
               end else begin
                  work_d = h_q;
               end
            end
         end
         UPDATE: begin
            if (!cnt_q[6]) begin
               work_d    = round_v;
               cnt_d     = cnt_q + 7'(R);
               sched_adv = 1'b1;
            end else begin
               for (int i = 0; i < 8; i++) begin
                  h_d[i] = h_q[i] + work_q[i];
               end
               state_d = last_q ? DONE : IDLE;
            end
         end
         DONE: begin
            if (take) begin
               state_d = IDLE;
               first_d = 1'b1;
            end
         end
         default: begin
            state_d = RESET;
         end
      endcase
   end

   // Registered output path: valid rises one cycle after DONE is entered.
   always_comb begin
      oval_d = (state_q == DONE) && !take;
      dout_d = masked;
   end

   // State register with synchronous active-low reset clearing everything.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= RESET;
         cnt_q   <= '0;
         work_q  <= '0;
         h_q     <= '0;
         first_q <= 1'b0;
         last_q  <= 1'b0;
         mode_q  <= 1'b0;
         oval_q  <= 1'b0;
         dout_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         work_q  <= work_d;
         h_q     <= h_d;
         first_q <= first_d;
         last_q  <= last_d;
         mode_q  <= mode_d;
         oval_q  <= oval_d;
         dout_q  <= dout_d;
      end
   end

endmodule

// File: tb/tb_sha2_compress_core.sv
// Self-checking bench: three core instances (R=1/OUT_REG=1, R=4/OUT_REG=1,
// R=2/OUT_REG=0) driven with known-answer vectors and random messages.
module tb_sha2_compress_core;

   localparam int NI = 3;
   localparam int RPC [NI] = '{1, 4, 2};
   localparam bit OREG [NI] = '{1'b1, 1'b1, 1'b0};

   localparam logic [511:0] ABC   = {32'h61626380, 416'h0, 64'h18};
   localparam logic [511:0] EMPTY = {32'h80000000, 480'h0};
   localparam logic [511:0] TWO1  = {448'h6162636462636465636465666465666765666768666768696768696a68696a6b696a6b6c6a6b6c6d6b6c6d6e6c6d6e6f6d6e6f706e6f7071,
                                     64'h8000000000000000};
   localparam logic [511:0] TWO2  = {448'h0, 64'h1c0};
   localparam logic [255:0] D256_ABC = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
   localparam logic [255:0] D224_ABC = {224'h23097d223405d8228642a477bda255b32aadbce4bda0b3f7e36c9da7, 32'h0};
   localparam logic [255:0] D_EMPTY  = 256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;
   localparam logic [255:0] D_TWO    = 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;

   localparam logic [31:0] TBK [64] = '{
      32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
      32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
      32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
      32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
      32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
      32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
      32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
      32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
   };
   localparam logic [31:0] IV256 [8] = '{32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
                                         32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
   localparam logic [31:0] IV224 [8] = '{32'hc1059ed8, 32'h367cd507, 32'h3070dd17, 32'hf70e5939,
                                         32'hffc00b31, 32'h68581511, 32'h64f98fa7, 32'hbefa4fa4};

   typedef struct packed {
      int                 inst;
      int                 nchunks;
      logic [0:2][511:0]  chs;
      logic               m224;
      int                 gap;
      int                 hold;
      logic               early;
      logic [255:0]       exp_dig;
      int                 exp_lat;
   } vec_t;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         mode_224     [NI];
   logic         chunk_valid  [NI];
   logic         chunk_ready  [NI];
   logic [511:0] chunk_data   [NI];
   logic         chunk_last   [NI];
   logic         digest_valid [NI];
   logic         digest_ready [NI];
   logic [255:0] digest       [NI];
   logic         busy         [NI];

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   for (genvar g = 0; g < NI; g++) begin : g_dut
      sha2_compress_core #(
         .ROUNDS_PER_CYCLE (RPC[g]),
         .OUT_REG          (OREG[g])
      ) u_dut (
         .clk          (clk),
         .rst_n        (rst_n),
         .mode_224     (mode_224[g]),
         .chunk_valid  (chunk_valid[g]),
         .chunk_ready  (chunk_ready[g]),
         .chunk_data   (chunk_data[g]),
         .chunk_last   (chunk_last[g]),
         .digest_valid (digest_valid[g]),
         .digest_ready (digest_ready[g]),
         .digest       (digest[g]),
         .busy         (busy[g])
      );
   end

   // Reference model: textbook SHA-2 with the full 64-word schedule array.
   function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
      return (x >> n) | (x << (32 - n));
   endfunction

   function automatic logic [255:0] model_digest(input logic [0:2][511:0] chs, input int n,
                                                 input logic m224);
      logic [31:0] hh [8];
      logic [31:0] ww [64];
      logic [31:0] v  [8];
      logic [31:0] t1, t2, s0, s1;
      logic [255:0] r;
      for (int i = 0; i < 8; i++) hh[i] = m224 ? IV224[i] : IV256[i];
      for (int blk = 0; blk < n; blk++) begin
         for (int t = 0; t < 16; t++) ww[t] = chs[blk][511-32*t -: 32];
         for (int t = 16; t < 64; t++) begin
            s0 = rotr(ww[t-15], 7) ^ rotr(ww[t-15], 18) ^ (ww[t-15] >> 3);
            s1 = rotr(ww[t-2], 17) ^ rotr(ww[t-2], 19) ^ (ww[t-2] >> 10);
            ww[t] = ww[t-16] + s0 + ww[t-7] + s1;
         end
         for (int i = 0; i < 8; i++) v[i] = hh[i];
         for (int t = 0; t < 64; t++) begin
            t1 = v[7] + (rotr(v[4], 6) ^ rotr(v[4], 11) ^ rotr(v[4], 25))
                 + ((v[4] & v[5]) ^ (~v[4] & v[6])) + TBK[t] + ww[t];
            t2 = (rotr(v[0], 2) ^ rotr(v[0], 13) ^ rotr(v[0], 22))
                 + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
            for (int i = 7; i > 0; i--) v[i] = v[i-1];
            v[4] = v[4] + t1;
            v[0] = t1 + t2;
         end
         for (int i = 0; i < 8; i++) hh[i] = hh[i] + v[i];
      end
      r = {hh[0], hh[1], hh[2], hh[3], hh[4], hh[5], hh[6], hh[7]};
      if (m224) r[31:0] = 32'h0;
      return r;
   endfunction

   function automatic vec_t mkVec(input int inst, input int n, input logic [0:2][511:0] chs,
                                  input logic m224, input int gap, input int hold,
                                  input logic early, input logic [255:0] exp_dig,
                                  input int exp_lat);
      vec_t v;
      v.inst = inst; v.nchunks = n; v.chs = chs; v.m224 = m224; v.gap = gap;
      v.hold = hold; v.early = early; v.exp_dig = exp_dig; v.exp_lat = exp_lat;
      return v;
   endfunction

   function automatic logic [511:0] randChunk();
      logic [511:0] c;
      for (int w = 0; w < 16; w++) c[511-32*w -: 32] = $urandom;
      return c;
   endfunction

   task automatic checkOutput(input string name, input logic [255:0] act, input logic [255:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic failBound(input string name, input int waited);
      checks++;
      errors++;
      $display("[TB] FAIL %s: no event after %0d cycles, event required within bound", name, waited);
   endtask

   task automatic checkResetOutputs(input int i);
      checkOutput("reset chunk_ready", chunk_ready[i], 1'b0);
      checkOutput("reset digest_valid", digest_valid[i], 1'b0);
      checkOutput("reset digest", digest[i], 256'h0);
      checkOutput("reset busy", busy[i], 1'b0);
   endtask

   // Offer one chunk and return at the first falling edge after it is accepted.
   task automatic applyStimulus(input int i, input logic [511:0] d, input logic last,
                                input logic m, output logic ok);
      int n;
      @(negedge clk);
      chunk_data[i]  = d;
      chunk_last[i]  = last;
      mode_224[i]    = m;
      chunk_valid[i] = 1'b1;
      n = 0;
      while (chunk_ready[i] !== 1'b1 && n < 300) begin
         @(negedge clk);
         n++;
      end
      ok = (chunk_ready[i] === 1'b1);
      if (!ok) begin
         failBound("chunk_ready", n);
         chunk_valid[i] = 1'b0;
      end else begin
         @(posedge clk);
         @(negedge clk);
         chunk_valid[i] = 1'b0;
         chunk_data[i]  = randChunk();
         chunk_last[i]  = $urandom_range(0, 1) != 0;
      end
   endtask

   task automatic runMessage(input int i, input logic [0:2][511:0] chs, input int n,
                             input logic m224, input int gap, input int hold, input logic early,
                             input logic [255:0] exp_dig, input int exp_lat,
                             output logic [255:0] dig);
      int   nr;
      int   k;
      int   bad;
      logic ok;
      nr  = 64 / RPC[i];
      dig = '0;
      digest_ready[i] = early;
      for (int c = 0; c < n; c++) begin
         applyStimulus(i, chs[c], (c == n - 1), (c == 0) ? m224 : ~m224, ok);
         if (!ok) return;
         if (c == 0) checkOutput("busy after accept", busy[i], 1'b1);
         if (c < n - 1) begin
            bad = 0;
            for (int kk = 0; kk <= nr; kk++) begin
               if (chunk_ready[i] !== 1'b0) bad++;
               chunk_valid[i] = (kk > 0) && (kk < nr);
               chunk_data[i]  = randChunk();
               @(negedge clk);
            end
            chunk_valid[i] = 1'b0;
            checkOutput("ready low while compressing", bad, 0);
            checkOutput("ready back after H update", chunk_ready[i], 1'b1);
            repeat (gap) @(negedge clk);
         end
      end
      k = 0;
      while (digest_valid[i] !== 1'b1 && k < 400) begin
         @(negedge clk);
         k++;
      end
      if (digest_valid[i] !== 1'b1) begin
         failBound("digest_valid", k);
         digest_ready[i] = 1'b0;
         return;
      end
      dig = digest[i];
      checkOutput("digest latency", k, exp_lat);
      checkOutput("digest value", dig, exp_dig);
      checkOutput("chunk_ready low in DONE", chunk_ready[i], 1'b0);
      for (int h = 0; h < hold; h++) begin
         chunk_valid[i] = 1'b1;
         chunk_data[i]  = randChunk();
         @(negedge clk);
         checkOutput("held digest_valid", digest_valid[i], 1'b1);
         checkOutput("held digest stable", digest[i], dig);
         checkOutput("held chunk_ready", chunk_ready[i], 1'b0);
      end
      chunk_valid[i]  = 1'b0;
      digest_ready[i] = 1'b1;
      @(negedge clk);
      checkOutput("digest_valid after take", digest_valid[i], 1'b0);
      checkOutput("busy after take", busy[i], 1'b0);
      checkOutput("chunk_ready after take", chunk_ready[i], 1'b1);
      digest_ready[i] = 1'b0;
   endtask

   initial begin
      #5000000;
      $display("[TB] FAIL watchdog: simulation time limit reached, required finish earlier");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      vec_t         vecs [6];
      logic [255:0] dig;
      logic         ok;
      int           inst, n, hold;
      logic         m;
      logic [0:2][511:0] chs;

      for (int i = 0; i < NI; i++) begin
         mode_224[i] = 1'b0; chunk_valid[i] = 1'b0; chunk_data[i] = '0;
         chunk_last[i] = 1'b0; digest_ready[i] = 1'b0;
      end

      vecs[0] = mkVec(0, 1, {ABC, 512'h0, 512'h0},   1'b0, 0, 0,  1'b0, D256_ABC, 66);
      vecs[1] = mkVec(1, 1, {EMPTY, 512'h0, 512'h0}, 1'b0, 0, 10, 1'b0, D_EMPTY,  18);
      vecs[2] = mkVec(2, 2, {TWO1, TWO2, 512'h0},    1'b0, 5, 0,  1'b1, D_TWO,    33);
      vecs[3] = mkVec(0, 1, {ABC, 512'h0, 512'h0},   1'b1, 0, 0,  1'b0, D224_ABC, 66);
      vecs[4] = mkVec(0, 1, {ABC, 512'h0, 512'h0},   1'b0, 0, 0,  1'b0, D256_ABC, 66);
      vecs[5] = mkVec(2, 1, {ABC, 512'h0, 512'h0},   1'b1, 0, 2,  1'b0, D224_ABC, 33);

      repeat (3) @(negedge clk);
      for (int i = 0; i < NI; i++) checkResetOutputs(i);
      rst_n = 1'b1;
      #1;
      checkOutput("RESET state not ready", chunk_ready[0], 1'b0);
      @(negedge clk);
      for (int i = 0; i < NI; i++) checkOutput("IDLE ready after reset", chunk_ready[i], 1'b1);

      for (int v = 0; v < 6; v++) begin
         runMessage(vecs[v].inst, vecs[v].chs, vecs[v].nchunks, vecs[v].m224, vecs[v].gap,
                    vecs[v].hold, vecs[v].early, vecs[v].exp_dig, vecs[v].exp_lat, dig);
         checkOutput("model digest", dig, model_digest(vecs[v].chs, vecs[v].nchunks, vecs[v].m224));
      end

      applyStimulus(1, ABC, 1'b1, 1'b0, ok);
      repeat (5) @(negedge clk);
      checkOutput("busy before mid-update reset", busy[1], 1'b1);
      rst_n = 1'b0;
      @(negedge clk);
      checkResetOutputs(1);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      runMessage(1, {ABC, 512'h0, 512'h0}, 1, 1'b0, 0, 0, 1'b0, D256_ABC, 18, dig);

      for (int r = 0; r < 10; r++) begin
         inst = $urandom_range(0, NI - 1);
         n    = $urandom_range(1, 3);
         m    = $urandom_range(0, 1) != 0;
         hold = $urandom_range(0, 3);
         chs  = {randChunk(), randChunk(), randChunk()};
         runMessage(inst, chs, n, m, $urandom_range(0, 3), hold, 1'b0,
                    model_digest(chs, n, m), 64 / RPC[inst] + 1 + int'(OREG[inst]), dig);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
